qbus_dma_arbiter: RTL
=====================

QBUS_DMA_ARBITER -- requirements
Module: qbus_dma_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of DMA requesters (2..8).
REQ-002 The block SHALL have parameter TMO_CYC, default 64, grant-acknowledge timeout in clk cycles (used only with the timeout feature).
REQ-003 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port dma_req  input  N_REQ  per-requester bus request, level, active-high.
REQ-006 The block SHALL have port dma_ack  input  N_REQ  per-requester ownership hold, active-high; high = bus taken, low = bus released.
REQ-007 The block SHALL have port dma_gnt  output  N_REQ  one-hot grant to requester.
REQ-008 The block SHALL have port dmr_n  output  1  Q-bus DMA request to CPU, active-low.
REQ-009 The block SHALL have port dmg_n  input  1  CPU DMA grant (CPU dmgo_n), active-low.
REQ-010 The block SHALL have port sack_n  output  1  Q-bus select acknowledge, active-low.
REQ-011 The block SHALL have port sync_n, rply_n  input  1 each  Q-bus handshake lines, observed for bus idle.
REQ-012 The block SHALL have port tmo_err  output  1  one-cycle timeout pulse.

Function
REQ-013 States SHALL be IDLE, REQ, WAITBUS, GNT, OWN, REL.
REQ-014 IDLE: any dma_req high -> REQ; dmr_n=0 from the next cycle.
REQ-015 REQ: dmr_n held 0; dmg_n=0 sampled -> WAITBUS; all dma_req low -> IDLE with dmr_n=1, even if dmg_n=0 in the same cycle.
REQ-016 WAITBUS: sync_n=1 and rply_n=1 sampled -> winner latched, GNT; otherwise stay. If no request is pending on the latching cycle -> IDLE.
REQ-017 Winner SHALL be the first requester with dma_req high, searching round-robin from pointer rr (reset 0) upward, wrapping at N_REQ-1 -> 0.
REQ-018 GNT: dma_gnt[winner]=1 and sack_n=0, both from the cycle after entry; dma_ack[winner]=1 -> OWN; dmr_n=1 from GNT onward.
REQ-019 OWN: dma_gnt[winner] cleared, sack_n held 0; dma_ack[winner]=0 -> REL.
REQ-020 REL: sack_n=1; rr=winner+1 modulo N_REQ; next state IDLE. A new arbitration SHALL need at least one IDLE cycle.
REQ-021 dma_gnt SHALL be one-hot or zero in every cycle, never asserted outside GNT.
REQ-022 dma_req changes of non-winners during GNT/OWN SHALL be ignored; dma_ack of non-winners SHALL be ignored.
REQ-023 The winner dropping dma_req in GNT without ack SHALL NOT abort the grant (only the timeout aborts it).

Reset
REQ-024 While rst_n=0 on a clock edge: state IDLE, rr=0, dmr_n=1, sack_n=1, dma_gnt=0, tmo_err=0, timeout counter 0.
REQ-025 Reset asserted in any state SHALL release all bus lines on the following edge with no REL cycle.

Configuration
REQ-026 With QBUS_ARB_TIMEOUT_EN defined: counter cleared on GNT entry; TMO_CYC cycles in GNT without ack -> tmo_err=1 for one cycle, dma_gnt=0, sack_n=1, rr=winner+1, state IDLE.
REQ-027 Without QBUS_ARB_TIMEOUT_EN: no counter logic; GNT waits indefinitely; tmo_err tied 0.

Structure
REQ-028 Shared package qbus_pkg SHALL hold the state enum type and the default constants for N_REQ and TMO_CYC.
REQ-029 The round-robin search SHALL be sub-module qbus_rr_pick (inputs req vector and pointer; outputs one-hot pick and valid).

Verification
REQ-030 dma_req=0001, dmg_n low 2 cycles after dmr_n=0, bus idle -> dma_gnt=0001, sack_n=0; ack 1 then 0 -> sack_n=1, rr=1.
REQ-031 dma_req=1111 held, ack each grant -> winner order 0,1,2,3,0.
REQ-032 sync_n=0 when dmg_n falls, held 5 cycles -> dma_gnt stays 0 until 1 cycle after sync_n=1 and rply_n=1.
REQ-033 dma_req=0100 withdrawn while in REQ -> dmr_n=1 next cycle, no grant, dmg_n then ignored.
REQ-034 QBUS_ARB_TIMEOUT_EN, TMO_CYC=8, no ack -> tmo_err pulses 8 cycles after GNT entry; sack_n=1; next grant goes to requester winner+1.
REQ-035 rst_n=0 during OWN -> dmr_n=1, sack_n=1, dma_gnt=0 on the next edge; rr=0.

Source files
------------

// File: rtl/qbus_pkg.sv
// rtl/qbus_pkg.sv - shared types and default constants for the Q-bus DMA arbiter
package qbus_pkg;

    localparam int QBUS_N_REQ_DEF   = 4;
    localparam int QBUS_TMO_CYC_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAITBUS = 3'd2,
        ST_GNT     = 3'd3,
        ST_OWN     = 3'd4,
        ST_REL     = 3'd5
    } qbus_state_e;

endpackage

// File: rtl/qbus_rr_pick.sv
// rtl/qbus_rr_pick.sv - round-robin pick of the first active request at or above a pointer
module qbus_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_pick,
    output logic             o_valid
);

    // Doubling the vector turns the wrap-around search into a plain upward scan.
    logic [2*N_REQ-1:0] w_req2;

    assign w_req2 = {i_req, i_req};

    // Scan upward from the pointer; the first hit folds back onto the real index.
    always_comb begin
        o_pick  = '0;
        o_valid = 1'b0;
        for (int k = 0; k < 2 * N_REQ; k++) begin
            if (!o_valid && (k >= int'(i_ptr)) && w_req2[k]) begin
                o_pick[k % N_REQ] = 1'b1;
                o_valid           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qbus_dma_arbiter.sv
// rtl/qbus_dma_arbiter.sv - Q-bus DMA arbiter, N requesters, optional grant timeout (QBUS_ARB_TIMEOUT_EN)
module qbus_dma_arbiter
    import qbus_pkg::*;
#(
    parameter int N_REQ   = QBUS_N_REQ_DEF,
    parameter int TMO_CYC = QBUS_TMO_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] dma_req,
    input  logic [N_REQ-1:0] dma_ack,
    output logic [N_REQ-1:0] dma_gnt,
    output logic             dmr_n,
    input  logic             dmg_n,
    output logic             sack_n,
    input  logic             sync_n,
    input  logic             rply_n,
    output logic             tmo_err
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    qbus_state_e      r_state;
    logic [IW-1:0]    r_rr;
    logic [IW-1:0]    r_win;
    logic [N_REQ-1:0] r_gnt;
    logic             r_dmr_n;
    logic             r_sack_n;

    logic [N_REQ-1:0] w_pick;
    logic             w_valid;
    logic [IW-1:0]    w_pick_idx;
    logic [IW-1:0]    w_rr_next;

`ifdef QBUS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0]    r_tmo_cnt;
    logic             r_tmo_err;
    assign tmo_err = r_tmo_err;
`else
    // Never fires in this build; the parameter stays referenced so both builds share one interface.
    assign tmo_err = (TMO_CYC < 0);
`endif

    qbus_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .i_req   (dma_req),
        .i_ptr   (r_rr),
        .o_pick  (w_pick),
        .o_valid (w_valid)
    );

    // Encode the one-hot pick so the winner can be held as a small index.
    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) w_pick_idx = IW'(i);
        end
    end

    assign w_rr_next = (r_win == IW'(N_REQ - 1)) ? '0 : r_win + 1'b1;

    assign dma_gnt = r_gnt;
    assign dmr_n   = r_dmr_n;
    assign sack_n  = r_sack_n;

    // Arbitration FSM with registered bus-side outputs; reset drops every line at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_rr     <= '0;
            r_win    <= '0;
            r_gnt    <= '0;
            r_dmr_n  <= 1'b1;
            r_sack_n <= 1'b1;
`ifdef QBUS_ARB_TIMEOUT_EN
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
`endif
        end else begin
`ifdef QBUS_ARB_TIMEOUT_EN
            r_tmo_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (|dma_req) begin
                        r_state <= ST_REQ;
                        r_dmr_n <= 1'b0;
                    end
                end
                ST_REQ: begin
                    // A withdrawn request wins over a grant arriving in the same cycle.
                    if (!(|dma_req)) begin
                        r_state <= ST_IDLE;
                        r_dmr_n <= 1'b1;
                    end else if (!dmg_n) begin
                        r_state <= ST_WAITBUS;
                    end
                end
                ST_WAITBUS: begin
                    if (sync_n && rply_n) begin
                        r_dmr_n <= 1'b1;
                        if (w_valid) begin
                            r_state  <= ST_GNT;
                            r_win    <= w_pick_idx;
                            r_gnt    <= w_pick;
                            r_sack_n <= 1'b0;
`ifdef QBUS_ARB_TIMEOUT_EN
                            r_tmo_cnt <= '0;
`endif
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_GNT: begin
                    if (dma_ack[r_win]) begin
                        r_state <= ST_OWN;
                        r_gnt   <= '0;
                    end
`ifdef QBUS_ARB_TIMEOUT_EN
                    else if (r_tmo_cnt == TW'(TMO_CYC - 1)) begin
                        r_state   <= ST_IDLE;
                        r_gnt     <= '0;
                        r_sack_n  <= 1'b1;
                        r_rr      <= w_rr_next;
                        r_tmo_err <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_OWN: begin
                    if (!dma_ack[r_win]) begin
                        r_state  <= ST_REL;
                        r_sack_n <= 1'b1;
                    end
                end
                ST_REL: begin
                    r_rr    <= w_rr_next;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
